rtc_port_manager: RTL and testbench

- Parametrised successor to the misc I/O manager, driven by the CPU's I/O opcode path.
- Holds a free-running calendar clock: seconds, minutes, hours, days, months and years, with automatic carry and Gregorian leap years.
- Also holds a small scratch register file, a run/halt control and registered read-back.
- Sits beside the core on the I/O chip-select; the CPU reads and sets time through ports instead of the block only displaying it.

---
 rtl/rtc_port_manager.sv | 259 +++++++++++++++++++++++++
 tb/tb_rtc_port_manager.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_port_manager.sv
// rtc_port_manager: calendar clock with port-mapped fields, scratch
// registers, a run/halt control and registered read-back.
// Optional alarm interrupt is built only when RTC_ALARM_EN is defined.
module rtc_port_manager #(
  parameter int DATA_SIZE     = 16,
  parameter int TICKS_PER_SEC = 100,
  parameter int SCRATCH_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic [3:0]           op,
  input  logic [DATA_SIZE-1:0] port,
  input  logic [DATA_SIZE-1:0] data,
  output logic [DATA_SIZE-1:0] result,
  output logic                 result_valid,
  output logic                 sec_tick,
  output logic                 irq
);

  localparam int IDX_W = $clog2(SCRATCH_DEPTH);
  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  localparam logic [3:0] OP_SCR_RD = 4'b0000;
  localparam logic [3:0] OP_SCR_WR = 4'b0001;
  localparam logic [3:0] OP_FLD_RD = 4'b0010;
  localparam logic [3:0] OP_FLD_WR = 4'b0011;

  localparam logic [DATA_SIZE-1:0] P_SEC  = DATA_SIZE'(0);
  localparam logic [DATA_SIZE-1:0] P_MIN  = DATA_SIZE'(1);
  localparam logic [DATA_SIZE-1:0] P_HOUR = DATA_SIZE'(2);
  localparam logic [DATA_SIZE-1:0] P_DAY  = DATA_SIZE'(3);
  localparam logic [DATA_SIZE-1:0] P_MON  = DATA_SIZE'(4);
  localparam logic [DATA_SIZE-1:0] P_YEAR = DATA_SIZE'(5);
  localparam logic [DATA_SIZE-1:0] P_CTRL = DATA_SIZE'(6);
`ifdef RTC_ALARM_EN
  localparam logic [DATA_SIZE-1:0] P_AHOUR = DATA_SIZE'(7);
  localparam logic [DATA_SIZE-1:0] P_AMIN  = DATA_SIZE'(8);
  localparam logic [DATA_SIZE-1:0] P_AEN   = DATA_SIZE'(9);
`endif

  logic [PRE_W-1:0]     prescaler;
  logic                 pending_tick;
  logic                 halt;
  logic [DATA_SIZE-1:0] scratch [SCRATCH_DEPTH];
  logic [DATA_SIZE-1:0] seconds, minutes, hours, days, months, years;
  logic [DATA_SIZE-1:0] sec_n, min_n, hour_n, day_n, mon_n, year_n;
  logic [DATA_SIZE-1:0] field_rd;
  logic [DATA_SIZE-1:0] resp;
  logic [IDX_W-1:0]     idx;
  logic                 tick_req;
  logic                 field_write;
  logic                 apply_tick;

`ifdef RTC_ALARM_EN
  logic [DATA_SIZE-1:0] alarm_hour, alarm_minute;
  logic                 alarm_en;
  logic                 alarm_hit;
`endif

  // Days in a month with Gregorian leap years; unknown months count as 31
  function automatic logic [DATA_SIZE-1:0] days_in_month(
    input logic [DATA_SIZE-1:0] m,
    input logic [DATA_SIZE-1:0] y
  );
    logic [31:0] mm;
    logic [31:0] yy;
    logic        leap;
    mm = 32'(m);
    yy = 32'(y);
    leap = (((yy % 32'd4) == 32'd0) && ((yy % 32'd100) != 32'd0)) ||
           ((yy % 32'd400) == 32'd0);
    case (mm)
      32'd2:                         return leap ? DATA_SIZE'(29) : DATA_SIZE'(28);
      32'd4, 32'd6, 32'd9, 32'd11:   return DATA_SIZE'(30);
      default:                       return DATA_SIZE'(31);
    endcase
  endfunction

  assign idx         = port[IDX_W-1:0];
  assign tick_req    = !halt && (prescaler == PRE_MAX);
  assign field_write = cs && (op == OP_FLD_WR);
  assign apply_tick  = !field_write && (tick_req || pending_tick);

  // One-second advance of the whole calendar, rippling every carry at once
  always_comb begin
    sec_n  = seconds;
    min_n  = minutes;
    hour_n = hours;
    day_n  = days;
    mon_n  = months;
    year_n = years;
    if (seconds >= DATA_SIZE'(59)) begin
      sec_n = '0;
      if (minutes >= DATA_SIZE'(59)) begin
        min_n = '0;
        if (hours >= DATA_SIZE'(23)) begin
          hour_n = '0;
          if (days >= days_in_month(months, years)) begin
            day_n = DATA_SIZE'(1);
            if (months >= DATA_SIZE'(12)) begin
              mon_n  = DATA_SIZE'(1);
              year_n = years + DATA_SIZE'(1);
            end else begin
              mon_n = months + DATA_SIZE'(1);
            end
          end else begin
            day_n = days + DATA_SIZE'(1);
          end
        end else begin
          hour_n = hours + DATA_SIZE'(1);
        end
      end else begin
        min_n = minutes + DATA_SIZE'(1);
      end
    end else begin
      sec_n = seconds + DATA_SIZE'(1);
    end
  end

`ifdef RTC_ALARM_EN
  assign alarm_hit = alarm_en && (hour_n == alarm_hour) &&
                     (min_n == alarm_minute) && (sec_n == '0);
`endif

  // Field read mux, always showing the values before this cycle's update
  always_comb begin
    field_rd = '0;
    case (port)
      P_SEC:   field_rd = seconds;
      P_MIN:   field_rd = minutes;
      P_HOUR:  field_rd = hours;
      P_DAY:   field_rd = days;
      P_MON:   field_rd = months;
      P_YEAR:  field_rd = years;
      P_CTRL:  field_rd = {{(DATA_SIZE-1){1'b0}}, halt};
`ifdef RTC_ALARM_EN
      P_AHOUR: field_rd = alarm_hour;
      P_AMIN:  field_rd = alarm_minute;
      P_AEN:   field_rd = {{(DATA_SIZE-1){1'b0}}, alarm_en};
`endif
      default: field_rd = '0;
    endcase
  end

  // Response value for the accepted operation
  always_comb begin
    resp = '0;
    case (op)
      OP_SCR_RD: resp = scratch[idx];
      OP_SCR_WR: resp = data;
      OP_FLD_RD: resp = field_rd;
      default:   resp = '0;
    endcase
  end

  // Prescaler divides clk down to the one-second tick and freezes while halted
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (!halt) begin
      prescaler <= tick_req ? '0 : prescaler + PRE_W'(1);
    end
  end

  // Registered response: valid for one cycle, data held between requests
  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= cs;
      if (cs) begin
        result <= resp;
      end
    end
  end

  // Scratch register file
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SCRATCH_DEPTH; i++) begin
        scratch[i] <= '0;
      end
    end else if (cs && (op == OP_SCR_WR)) begin
      scratch[idx] <= data;
    end
  end

  // Time-keeping state: a field write wins the cycle and defers any tick
  always_ff @(posedge clk) begin
    if (rst) begin
      seconds      <= '0;
      minutes      <= '0;
      hours        <= '0;
      days         <= DATA_SIZE'(1);
      months       <= DATA_SIZE'(1);
      years        <= '0;
      halt         <= 1'b0;
      pending_tick <= 1'b0;
      sec_tick     <= 1'b0;
`ifdef RTC_ALARM_EN
      alarm_hour   <= '0;
      alarm_minute <= '0;
      alarm_en     <= 1'b0;
`endif
    end else begin
      sec_tick <= apply_tick;
      if (field_write) begin
        pending_tick <= pending_tick | tick_req;
        case (port)
          P_SEC:   seconds <= data;
          P_MIN:   minutes <= data;
          P_HOUR:  hours   <= data;
          P_DAY:   days    <= data;
          P_MON:   months  <= data;
          P_YEAR:  years   <= data;
          P_CTRL: begin
            halt <= data[0];
            if (data[0]) begin
              pending_tick <= 1'b0;
            end
          end
`ifdef RTC_ALARM_EN
          P_AHOUR: alarm_hour   <= data;
          P_AMIN:  alarm_minute <= data;
          P_AEN:   alarm_en     <= data[0];
`endif
          default: ;
        endcase
      end else begin
        pending_tick <= 1'b0;
        if (apply_tick) begin
          seconds <= sec_n;
          minutes <= min_n;
          hours   <= hour_n;
          days    <= day_n;
          months  <= mon_n;
          years   <= year_n;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  // Alarm pulse lines up with the sec_tick that lands on the alarm time
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= apply_tick && alarm_hit;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_port_manager.sv
// Testbench for rtc_port_manager: directed calendar scenarios plus random
// traffic, checked by a scoreboard against a behavioural calendar model.
module tb_rtc_port_manager;

  localparam int DS  = 16;
  localparam int TPS = 4;
  localparam int SD  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0;
  logic [3:0]    op = 4'd0;
  logic [DS-1:0] port = '0;
  logic [DS-1:0] data = '0;
  logic [DS-1:0] result;
  logic          result_valid;
  logic          sec_tick;
  logic          irq;

  rtc_port_manager #(.DATA_SIZE(DS), .TICKS_PER_SEC(TPS), .SCRATCH_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .cs(cs), .op(op), .port(port), .data(data),
    .result(result), .result_valid(result_valid), .sec_tick(sec_tick), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic          tick;
    logic          irq;
    logic [DS-1:0] hold;
  } cycle_t;

  cycle_t        cyc_q[$];
  logic [DS-1:0] res_q[$];
  int            n_vec  = 0;
  int            n_miss = 0;

  // Behavioural reference state
  logic [DS-1:0] m_sec, m_min, m_hr, m_day, m_mon, m_yr, m_res, m_ah, m_am;
  logic          m_halt, m_pend, m_aen;
  int            m_presc;
  logic [DS-1:0] m_scr [SD];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int month_len(input int mon, input int yr);
    bit leap;
    leap = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
    if (mon == 2) return leap ? 29 : 28;
    if (mon == 4 || mon == 6 || mon == 9 || mon == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hr = 0; m_day = 1; m_mon = 1; m_yr = 0;
    m_res = 0; m_halt = 0; m_pend = 0; m_presc = 0;
    m_ah = 0; m_am = 0; m_aen = 0;
    for (int i = 0; i < SD; i++) m_scr[i] = 0;
  endtask

  task automatic model_second();
    if (m_sec < 59) begin m_sec++; return; end
    m_sec = 0;
    if (m_min < 59) begin m_min++; return; end
    m_min = 0;
    if (m_hr < 23) begin m_hr++; return; end
    m_hr = 0;
    if (int'(m_day) < month_len(int'(m_mon), int'(m_yr))) begin m_day++; return; end
    m_day = 1;
    if (m_mon < 12) begin m_mon++; return; end
    m_mon = 1;
    m_yr = m_yr + 16'd1;
  endtask

  function automatic logic [DS-1:0] model_field(input logic [DS-1:0] p);
    case (p)
      16'd0: return m_sec;
      16'd1: return m_min;
      16'd2: return m_hr;
      16'd3: return m_day;
      16'd4: return m_mon;
      16'd5: return m_yr;
      16'd6: return {15'd0, m_halt};
`ifdef RTC_ALARM_EN
      16'd7: return m_ah;
      16'd8: return m_am;
      16'd9: return {15'd0, m_aen};
`endif
      default: return 16'd0;
    endcase
  endfunction

  task automatic model_write(input logic [DS-1:0] p, input logic [DS-1:0] d);
    case (p)
      16'd0: m_sec = d;
      16'd1: m_min = d;
      16'd2: m_hr  = d;
      16'd3: m_day = d;
      16'd4: m_mon = d;
      16'd5: m_yr  = d;
      16'd6: begin m_halt = d[0]; if (d[0]) m_pend = 0; end
`ifdef RTC_ALARM_EN
      16'd7: m_ah  = d;
      16'd8: m_am  = d;
      16'd9: m_aen = d[0];
`endif
      default: ;
    endcase
  endtask

  // Drive one request cycle and push the model's expected response
  task automatic applyStimulus(input logic r, input logic c, input logic [3:0] o,
                               input logic [DS-1:0] p, input logic [DS-1:0] d);
    cycle_t e;
    logic   tick_req;
    logic   fw;
    @(negedge clk);
    rst = r; cs = c; op = o; port = p; data = d;
    e.valid = 0; e.tick = 0; e.irq = 0;
    if (r) begin
      model_reset();
      e.hold = 0;
      cyc_q.push_back(e);
      return;
    end
    tick_req = !m_halt && (m_presc == TPS - 1);
    if (!m_halt) m_presc = tick_req ? 0 : m_presc + 1;
    if (c) begin
      case (o)
        4'd0:    m_res = m_scr[p[3:0]];
        4'd1:    m_res = d;
        4'd2:    m_res = model_field(p);
        default: m_res = 0;
      endcase
      res_q.push_back(m_res);
      e.valid = 1;
    end
    if (c && o == 4'd1) m_scr[p[3:0]] = d;
    fw = c && (o == 4'd3);
    if (fw) begin
      if (tick_req) m_pend = 1;
      model_write(p, d);
    end else begin
      e.tick = tick_req || m_pend;
      m_pend = 0;
      if (e.tick) begin
        model_second();
`ifdef RTC_ALARM_EN
        e.irq = m_aen && (m_hr == m_ah) && (m_min == m_am) && (m_sec == 0);
`endif
      end
    end
    e.hold = m_res;
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'd0, 16'd0, 16'd0);
  endtask

  task automatic wr(input logic [DS-1:0] p, input logic [DS-1:0] d);
    applyStimulus(0, 1, 4'd3, p, d);
  endtask

  task automatic rd(input logic [DS-1:0] p);
    applyStimulus(0, 1, 4'd2, p, 16'd0);
  endtask

  task automatic set_time(input int hh, input int mi, input int ss,
                          input int dd, input int mo, input int yy);
    wr(16'd2, 16'(hh)); wr(16'd1, 16'(mi)); wr(16'd0, 16'(ss));
    wr(16'd3, 16'(dd)); wr(16'd4, 16'(mo)); wr(16'd5, 16'(yy));
  endtask

  task automatic read_all();
    for (int i = 0; i < 6; i++) rd(16'(i));
  endtask

  // Monitor: compare every cycle, pop a result whenever the DUT presents one
  initial begin
    cycle_t        c;
    logic [DS-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() == 0) continue;
      c = cyc_q.pop_front();
      checkOutput("result_valid", 32'(result_valid), 32'(c.valid));
      checkOutput("sec_tick", 32'(sec_tick), 32'(c.tick));
      checkOutput("irq", 32'(irq), 32'(c.irq));
      if (result_valid) begin
        if (res_q.size() == 0) begin
          checkOutput("unexpected_result", 32'(result_valid), 32'd0);
        end else begin
          e = res_q.pop_front();
          checkOutput("result", 32'(result), 32'(e));
        end
      end else begin
        checkOutput("result_hold", 32'(result), 32'(c.hold));
      end
    end
  end

  initial begin
    logic [DS-1:0] rp, rdat;
    logic [3:0]    rop;
    int            sel;

    model_reset();
    applyStimulus(1, 0, 4'd0, 16'd0, 16'd0);
    applyStimulus(1, 1, 4'd3, 16'd0, 16'd9);
    read_all();

    // Year rollover
    applyStimulus(1, 0, 4'd0, 16'd0, 16'd0);
    set_time(23, 59, 58, 31, 12, 1999);
    idle(8);
    read_all();

    // Leap-year boundaries
    set_time(23, 59, 59, 28, 2, 2000);  idle(TPS + 2); read_all();
    set_time(23, 59, 59, 28, 2, 1900);  idle(TPS + 2); read_all();
    set_time(23, 59, 59, 29, 2, 2024);  idle(TPS + 2); read_all();

    // Field write landing exactly on a tick cycle
    for (int i = 0; i < 3 * TPS && !(m_presc == TPS - 1 && !m_halt && !m_pend); i++) idle(1);
    wr(16'd0, 16'd10);
    rd(16'd0);
    rd(16'd0);

    // Out-of-range seconds normalise on the next tick
    wr(16'd0, 16'd75);
    idle(TPS + 1);
    rd(16'd0); rd(16'd1);

    // Scratch aliasing, unknown op, deselected requests
    applyStimulus(0, 1, 4'd1, 16'd3, 16'hBEEF);
    applyStimulus(0, 1, 4'd0, 16'(3 + SD), 16'd0);
    applyStimulus(0, 1, 4'd5, 16'd2, 16'h1234);
    applyStimulus(0, 0, 4'd2, 16'd0, 16'd0);
    applyStimulus(0, 0, 4'd1, 16'd4, 16'h5555);
    applyStimulus(0, 1, 4'd0, 16'd4, 16'd0);

`ifdef RTC_ALARM_EN
    // Alarm fires only when enabled
    wr(16'd7, 16'd7); wr(16'd8, 16'd30); wr(16'd9, 16'd1);
    set_time(7, 29, 59, 1, 1, 2020);
    idle(2 * TPS);
    rd(16'd7); rd(16'd8); rd(16'd9);
    wr(16'd9, 16'd0);
    set_time(7, 29, 59, 1, 1, 2020);
    idle(2 * TPS);
`endif

    // Halt freezes the clock
    wr(16'd6, 16'd1);
    idle(20);
    rd(16'd6); rd(16'd0);
    wr(16'd6, 16'd0);
    idle(TPS + 1);
    rd(16'd0);

    // Random traffic with a mid-run reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        applyStimulus(1, 1, 4'd3, 16'd0, 16'd42);
        continue;
      end
      sel  = $urandom_range(0, 99);
      rop  = (sel < 90) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      rp   = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 11));
      rdat = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      if (rop == 4'd3 && rp == 16'd6 && $urandom_range(0, 1) == 0) rdat[0] = 1'b0;
      applyStimulus(0, ($urandom_range(0, 99) < 70), rop, rp, rdat);
    end
    read_all();

    idle(3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("leftover_results", 32'(res_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
